// File: rtl/jtkiwi_objdraw.sv
// jtkiwi_objdraw: per-line sprite engine scanning the object table into a ping-pong line buffer
module jtkiwi_objdraw #(
    parameter int         OBJW        = 9,
    parameter int         PALW        = 5,
    parameter int         CODEW       = 14,
    parameter logic [8:0] FLIP_OFFSET = 9'h100
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 pxl_cen,
    input  logic                 hs,
    input  logic                 flip,
    input  logic [8:0]           vrender,
    input  logic [8:0]           hdump,
    output logic [OBJW-1:0]      tbl_addr,
    input  logic [7:0]           tbl_y,
    input  logic [8:0]           tbl_x,
    input  logic [CODEW-1:0]     tbl_code,
    input  logic                 tbl_xflip,
    input  logic                 tbl_yflip,
    input  logic [PALW-1:0]      tbl_pal,
    output logic [CODEW+4:0]     rom_addr,
    output logic                 rom_cs,
    input  logic                 rom_ok,
    input  logic [31:0]          rom_data,
    output logic [PALW+3:0]      pxl,
    output logic                 busy,
    output logic                 overrun
);
    typedef enum logic [2:0] {IDLE, READ, MATCH, FETCH, DRAW, NEXT} state_t;

    state_t            st, st_nx;
    logic              hs_l, bank, xflip, h;
    logic [8:0]        x, vline, scr_x, buf_x;
    logic [CODEW-1:0]  code;
    logic [PALW-1:0]   pal;
    logic [3:0]        row, nib;
    logic [2:0]        cnt, nib_idx;
    logic [31:0]       pix;
    logic [7:0]        ydiff;
    logic              hs_edge, draw_we, unused_vline_msb;
    logic [PALW+3:0]   lbuf [0:1023];

    assign hs_edge          = hs & ~hs_l;
    assign vline            = flip ? ~vrender : vrender;
    assign unused_vline_msb = vline[8];
    assign ydiff            = vline[7:0] - tbl_y;
    assign nib_idx          = cnt ^ {3{xflip}};
    assign nib              = pix[{nib_idx, 2'b00} +: 4];
    assign scr_x            = x + {5'd0, h, cnt};
    assign buf_x            = flip ? FLIP_OFFSET - scr_x : scr_x;
    assign draw_we          = st == DRAW && nib != 4'd0;
    assign rom_cs           = st == FETCH;
    assign rom_addr         = {code, row, h ^ xflip};

    // Next-state logic; a new line always restarts the scan
    always_comb begin
        st_nx = st;
        if (hs_edge) st_nx = READ;
        else begin
            unique case (st)
                IDLE:    st_nx = IDLE;
                READ:    st_nx = MATCH;
                MATCH:   st_nx = ydiff[7:4] == 4'd0 ? FETCH : NEXT;
                FETCH:   st_nx = rom_ok ? DRAW : FETCH;
                DRAW:    st_nx = cnt == 3'd7 ? (h ? NEXT : FETCH) : DRAW;
                NEXT:    st_nx = tbl_addr == '0 ? IDLE : READ;
                default: st_nx = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    // Scan datapath: bank swap, table walk and per-object latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_l     <= 1'b0;
            bank     <= 1'b0;
            tbl_addr <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            x        <= '0;
            code     <= '0;
            pal      <= '0;
            xflip    <= 1'b0;
            row      <= '0;
            h        <= 1'b0;
            cnt      <= '0;
            pix      <= '0;
        end else begin
            hs_l <= hs;
            if (hs_edge) begin
                bank     <= ~bank;
                overrun  <= overrun | busy;
                tbl_addr <= '1;
                busy     <= 1'b1;
            end else begin
                if (st == MATCH) begin
                    x     <= tbl_x;
                    code  <= tbl_code;
                    pal   <= tbl_pal;
                    xflip <= tbl_xflip;
                    row   <= ydiff[3:0] ^ {4{tbl_yflip}};
                    h     <= 1'b0;
                end
                if (st == FETCH && rom_ok) begin
                    pix <= rom_data;
                    cnt <= 3'd0;
                end
                if (st == DRAW) begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) h <= 1'b1;
                end
                if (st == NEXT) begin
                    if (tbl_addr == '0) busy <= 1'b0;
                    else                tbl_addr <= tbl_addr - 1'b1;
                end
            end
        end
    end

    // Line buffer: opaque draws into the write bank, erase-after-read on the other bank
    always_ff @(posedge clk) begin
        if (draw_we) lbuf[{bank, buf_x}] <= {pal, nib};
        if (pxl_cen) lbuf[{~bank, hdump}] <= '0;
    end

    // Pixel readout register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          pxl <= '0;
        else if (pxl_cen) pxl <= lbuf[{~bank, hdump}];
    end
endmodule

// File: tb/tb_jtkiwi_objdraw.sv
// tb_jtkiwi_objdraw: directed self-checking bench for the sprite line engine
module tb_jtkiwi_objdraw;
    localparam int OBJW = 9, PALW = 5, CODEW = 14;

    logic              rst = 1'b1, clk = 1'b0, pxl_cen = 1'b0, hs = 1'b0, flip = 1'b0;
    logic [8:0]        vrender = '0, hdump = '0;
    logic [OBJW-1:0]   tbl_addr;
    logic [7:0]        tbl_y;
    logic [8:0]        tbl_x;
    logic [CODEW-1:0]  tbl_code;
    logic              tbl_xflip, tbl_yflip;
    logic [PALW-1:0]   tbl_pal;
    logic [CODEW+4:0]  rom_addr;
    logic              rom_cs, rom_ok = 1'b0;
    logic [31:0]       rom_data = '0;
    logic [PALW+3:0]   pxl;
    logic              busy, overrun;

    int errors = 0, checks = 0;
    logic [7:0]        ty [0:511];
    logic [8:0]        tx [0:511];
    logic [CODEW-1:0]  tc [0:511];
    logic              txf [0:511];
    logic              tyf [0:511];
    logic [PALW-1:0]   tp [0:511];
    logic [31:0]       rt [0:3];
    logic              rom_stall = 1'b0;
    int                dly = 0;
    logic [CODEW+4:0]  rlog [$];
    logic [PALW+3:0]   line [0:511];
    logic [PALW+3:0]   v;

    jtkiwi_objdraw #(.OBJW(OBJW), .PALW(PALW), .CODEW(CODEW), .FLIP_OFFSET(9'h100)) dut (
        .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hs(hs), .flip(flip), .vrender(vrender),
        .hdump(hdump), .tbl_addr(tbl_addr), .tbl_y(tbl_y), .tbl_x(tbl_x), .tbl_code(tbl_code),
        .tbl_xflip(tbl_xflip), .tbl_yflip(tbl_yflip), .tbl_pal(tbl_pal), .rom_addr(rom_addr),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data), .pxl(pxl), .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // object table with one clock of read latency
    always @(posedge clk) begin
        tbl_y     <= ty[tbl_addr];
        tbl_x     <= tx[tbl_addr];
        tbl_code  <= tc[tbl_addr];
        tbl_xflip <= txf[tbl_addr];
        tbl_yflip <= tyf[tbl_addr];
        tbl_pal   <= tp[tbl_addr];
    end

    // ROM answering two clocks after a request; words chosen by code lsb and half
    always @(posedge clk) begin
        if (rom_cs && rom_ok) rlog.push_back(rom_addr);
        if (rom_cs && !rom_ok && !rom_stall) begin
            if (dly == 1) begin
                rom_ok   <= 1'b1;
                rom_data <= rt[{rom_addr[5], rom_addr[0]}];
                dly      <= 0;
            end else dly <= dly + 1;
        end else begin
            rom_ok <= 1'b0;
            if (!rom_cs) dly <= 0;
        end
    end

    task automatic clear_table;
        for (int i = 0; i < 512; i++) begin
            ty[i] = 8'hF0; tx[i] = '0; tc[i] = '0; txf[i] = 1'b0; tyf[i] = 1'b0; tp[i] = '0;
        end
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic pulse_hs;
        wait_idle();
        @(negedge clk) hs = 1'b1;
        @(negedge clk);
        @(negedge clk) hs = 1'b0;
    endtask

    task automatic read_line;
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (i > 0) line[i-1] = pxl;
            hdump   = 9'(i);
            pxl_cen = i < 512;
        end
    endtask

    task automatic read_px(input logic [8:0] a, output logic [PALW+3:0] r);
        @(negedge clk);
        hdump   = a;
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        r = pxl;
    endtask

    task automatic do_line;
        pulse_hs();
        read_line();
        wait_idle();
    endtask

    task automatic set_obj5(input logic [8:0] xx, input logic xf, input logic yf);
        clear_table();
        ty[5] = 8'h20; tx[5] = xx; tc[5] = 14'h123; tp[5] = 5'd3; txf[5] = xf; tyf[5] = yf;
        rt[2] = 32'h87654321;
        rt[3] = 32'hFEDCBA99;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (pxl !== '0)      begin errors++; $display("FAIL reset_pxl: got %h required 0", pxl); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b required 0", rom_cs); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b required 0", overrun); end
        checks++; if (tbl_addr !== '0) begin errors++; $display("FAIL reset_tbl_addr: got %h required 0", tbl_addr); end
        clear_table();
        do_line();
        do_line();
    endtask

    task automatic test_basic;
        logic [31:0] w1 = 32'hFEDCBA99;
        set_obj5(9'h040, 1'b0, 1'b0);
        vrender = 9'h022;
        rlog.delete();
        do_line();
        checks++; if (rlog.size() < 2 || rlog[0] !== 19'h02464) begin errors++; $display("FAIL basic_rom0: got %h required 02464", rlog.size() > 0 ? rlog[0] : 19'h0); end
        checks++; if (rlog.size() < 2 || rlog[1] !== 19'h02465) begin errors++; $display("FAIL basic_rom1: got %h required 02465", rlog.size() > 1 ? rlog[1] : 19'h0); end
        do_line();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (line[9'h040 + i] !== {5'd3, 4'(i + 1)}) begin
                errors++; $display("FAIL basic_lo%0d: got %h required %h", i, line[9'h040 + i], {5'd3, 4'(i + 1)});
            end
            checks++;
            if (line[9'h048 + i] !== {5'd3, w1[4*i +: 4]}) begin
                errors++; $display("FAIL basic_hi%0d: got %h required %h", i, line[9'h048 + i], {5'd3, w1[4*i +: 4]});
            end
        end
        checks++; if (line[9'h03F] !== '0) begin errors++; $display("FAIL basic_left: got %h required 0", line[9'h03F]); end
        checks++; if (line[9'h050] !== '0) begin errors++; $display("FAIL basic_right: got %h required 0", line[9'h050]); end
        read_px(9'h040, v);
        checks++; if (v !== '0) begin errors++; $display("FAIL basic_erase: got %h required 0", v); end
    endtask

    task automatic test_xflip;
        set_obj5(9'h040, 1'b1, 1'b0);
        rlog.delete();
        do_line();
        checks++; if (rlog.size() < 1 || rlog[0] !== 19'h02465) begin errors++; $display("FAIL xflip_rom0: got %h required 02465", rlog.size() > 0 ? rlog[0] : 19'h0); end
        checks++; if (rlog.size() < 2 || rlog[1] !== 19'h02464) begin errors++; $display("FAIL xflip_rom1: got %h required 02464", rlog.size() > 1 ? rlog[1] : 19'h0); end
        do_line();
        checks++; if (line[9'h040] !== 9'h03F) begin errors++; $display("FAIL xflip_px40: got %h required 03f", line[9'h040]); end
        checks++; if (line[9'h047] !== 9'h039) begin errors++; $display("FAIL xflip_px47: got %h required 039", line[9'h047]); end
        checks++; if (line[9'h048] !== 9'h038) begin errors++; $display("FAIL xflip_px48: got %h required 038", line[9'h048]); end
        checks++; if (line[9'h04F] !== 9'h031) begin errors++; $display("FAIL xflip_px4f: got %h required 031", line[9'h04F]); end
    endtask

    task automatic test_yflip;
        set_obj5(9'h040, 1'b0, 1'b1);
        rlog.delete();
        do_line();
        checks++; if (rlog.size() < 1 || rlog[0] !== 19'h0247A) begin errors++; $display("FAIL yflip_rom0: got %h required 0247a", rlog.size() > 0 ? rlog[0] : 19'h0); end
        checks++; if (rlog.size() < 2 || rlog[1] !== 19'h0247B) begin errors++; $display("FAIL yflip_rom1: got %h required 0247b", rlog.size() > 1 ? rlog[1] : 19'h0); end
        do_line();
        checks++; if (line[9'h040] !== 9'h031) begin errors++; $display("FAIL yflip_px40: got %h required 031", line[9'h040]); end
        checks++; if (line[9'h047] !== 9'h038) begin errors++; $display("FAIL yflip_px47: got %h required 038", line[9'h047]); end
    endtask

    task automatic test_priority;
        clear_table();
        ty[0] = 8'h20; tx[0] = 9'h100; tc[0] = 14'h010; tp[0] = 5'd1;
        ty[1] = 8'h20; tx[1] = 9'h100; tc[1] = 14'h011; tp[1] = 5'd2;
        rt[0] = 32'h22222202; rt[1] = 32'h22222222;
        rt[2] = 32'h33333333; rt[3] = 32'h33333333;
        vrender = 9'h022;
        do_line();
        do_line();
        checks++; if (line[9'h100] !== 9'h012) begin errors++; $display("FAIL prio_px100: got %h required 012", line[9'h100]); end
        checks++; if (line[9'h101] !== 9'h023) begin errors++; $display("FAIL prio_px101: got %h required 023", line[9'h101]); end
        checks++; if (line[9'h102] !== 9'h012) begin errors++; $display("FAIL prio_px102: got %h required 012", line[9'h102]); end
        checks++; if (line[9'h10F] !== 9'h012) begin errors++; $display("FAIL prio_px10f: got %h required 012", line[9'h10F]); end
    endtask

    task automatic test_wrap;
        set_obj5(9'h1FC, 1'b0, 1'b0);
        do_line();
        do_line();
        checks++; if (line[9'h1FC] !== 9'h031) begin errors++; $display("FAIL wrap_px1fc: got %h required 031", line[9'h1FC]); end
        checks++; if (line[9'h1FF] !== 9'h034) begin errors++; $display("FAIL wrap_px1ff: got %h required 034", line[9'h1FF]); end
        checks++; if (line[9'h000] !== 9'h035) begin errors++; $display("FAIL wrap_px000: got %h required 035", line[9'h000]); end
        checks++; if (line[9'h003] !== 9'h038) begin errors++; $display("FAIL wrap_px003: got %h required 038", line[9'h003]); end
        checks++; if (line[9'h004] !== 9'h039) begin errors++; $display("FAIL wrap_px004: got %h required 039", line[9'h004]); end
    endtask

    task automatic test_flip;
        set_obj5(9'h040, 1'b0, 1'b0);
        flip    = 1'b1;
        vrender = 9'h1DD;
        do_line();
        do_line();
        checks++; if (line[9'h0C0] !== 9'h031) begin errors++; $display("FAIL flip_px0c0: got %h required 031", line[9'h0C0]); end
        checks++; if (line[9'h0BF] !== 9'h032) begin errors++; $display("FAIL flip_px0bf: got %h required 032", line[9'h0BF]); end
        checks++; if (line[9'h0B9] !== 9'h038) begin errors++; $display("FAIL flip_px0b9: got %h required 038", line[9'h0B9]); end
        checks++; if (line[9'h0B8] !== 9'h039) begin errors++; $display("FAIL flip_px0b8: got %h required 039", line[9'h0B8]); end
        checks++; if (line[9'h040] !== '0)     begin errors++; $display("FAIL flip_px040: got %h required 0", line[9'h040]); end
        flip    = 1'b0;
        vrender = 9'h022;
    endtask

    task automatic test_overrun;
        int n = 0;
        set_obj5(9'h040, 1'b0, 1'b0);
        rom_stall = 1'b1;
        pulse_hs();
        while (!rom_cs && n < 4000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL ovr_stalled: rom_cs=%b required 1", rom_cs); end
        @(negedge clk) hs = 1'b1;
        @(negedge clk);
        checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL ovr_flag: got %b required 1", overrun); end
        checks++; if (rom_cs !== 1'b0)    begin errors++; $display("FAIL ovr_rom_cs: got %b required 0", rom_cs); end
        checks++; if (tbl_addr !== 9'h1FF) begin errors++; $display("FAIL ovr_tbl_addr: got %h required 1ff", tbl_addr); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL ovr_busy: got %b required 1", busy); end
        hs = 1'b0;
    endtask

    task automatic test_reset_draw;
        int n = 0;
        rom_stall = 1'b0;
        while (!rom_cs && n < 4000) begin @(negedge clk); n++; end
        n = 0;
        while (rom_cs && n < 50) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b1 || rom_cs !== 1'b0) begin errors++; $display("FAIL rdraw_pre: busy=%b rom_cs=%b required 1 0", busy, rom_cs); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rdraw_busy: got %b required 0", busy); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL rdraw_overrun: got %b required 0", overrun); end
        checks++; if (rom_cs !== 1'b0)   begin errors++; $display("FAIL rdraw_rom_cs: got %b required 0", rom_cs); end
        checks++; if (pxl !== '0)        begin errors++; $display("FAIL rdraw_pxl: got %h required 0", pxl); end
        checks++; if (tbl_addr !== '0)   begin errors++; $display("FAIL rdraw_tbl_addr: got %h required 0", tbl_addr); end
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        clear_table();
        rt[0] = '0; rt[1] = '0; rt[2] = '0; rt[3] = '0;
        test_reset();
        test_basic();
        test_xflip();
        test_yflip();
        test_priority();
        test_wrap();
        test_flip();
        test_overrun();
        test_reset_draw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
